// File: rtl/rv_soc_pkg.sv
// Shared constants for the SoC program loader: FSM encodings, frame sync byte
// and default parameter values.
package rv_soc_pkg;

    localparam int          IMEM_BYTES_DEF  = 1024;
    localparam int          TIMEOUT_CYC_DEF = 100000;
    localparam int          RST_CYC_DEF     = 4;
    localparam logic [7:0]  SYNC_BYTE_DEF   = 8'hA5;

    localparam logic [2:0]  ST_RUN     = 3'd0;
    localparam logic [2:0]  ST_LEN_LO  = 3'd1;
    localparam logic [2:0]  ST_LEN_HI  = 3'd2;
    localparam logic [2:0]  ST_DATA    = 3'd3;
    localparam logic [2:0]  ST_CSUM    = 3'd4;
    localparam logic [2:0]  ST_RELEASE = 3'd5;
    localparam logic [2:0]  ST_ERR     = 3'd6;

endpackage

// File: rtl/rv_pgm_timeout.sv
// Inter-byte gap timer: counts enabled cycles since the last load and flags
// expiry once TIMEOUT_CYC cycles have elapsed without a reload.
module rv_pgm_timeout
    import rv_soc_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_enable,
    output logic o_expire
);

    logic [31:0] r_cnt;
    logic        w_expire;

    assign w_expire = i_enable && !i_load && (r_cnt == 32'(TIMEOUT_CYC - 1));
    assign o_expire = w_expire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_enable && !w_expire) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/rv_pgm_loader.sv
// UART program loader: receives SYNC, 16-bit LE length, payload and an 8-bit
// sum checksum, writes the payload into instruction memory, then pulses core
// reset. Define RV_PGM_LOADER_TIMEOUT_EN to abort frames on inter-byte gaps.
//
// rx handshake: rx_valid is a one-cycle strobe with no backpressure; every
// strobe is consumed in the cycle it is seen.
module rv_pgm_loader
    import rv_soc_pkg::*;
#(
    parameter int         IMEM_BYTES  = IMEM_BYTES_DEF,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int         RST_CYC     = RST_CYC_DEF
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       hlt,
    output logic       pgm_mode,
    output logic       inst_mem_we,
    output logic [9:0] pgm_addr,
    output logic [7:0] pgm_data,
    output logic       core_rst,
    output logic       load_done,
    output logic       load_err,
    output logic [2:0] dbg_state
);

    logic [2:0]  r_state;
    logic        r_hlt, r_pgm_mode, r_we, r_core_rst, r_load_done, r_load_err;
    logic [9:0]  r_addr, r_idx;
    logic [7:0]  r_data, r_len_lo, r_csum;
    logic [15:0] r_len, r_rst_cnt;
    logic [15:0] w_len_rx;
    logic        w_len_bad, w_last, w_sync, w_in_frame, w_timeout;

    assign w_len_rx   = {rx_data, r_len_lo};
    assign w_len_bad  = (w_len_rx == 16'd0) || (w_len_rx > 16'(IMEM_BYTES));
    assign w_last     = ({6'd0, r_idx} == (r_len - 16'd1));
    assign w_sync     = rx_valid && (rx_data == SYNC_BYTE);
    assign w_in_frame = (r_state == ST_LEN_LO) || (r_state == ST_LEN_HI) ||
                        (r_state == ST_DATA)   || (r_state == ST_CSUM);

`ifdef RV_PGM_LOADER_TIMEOUT_EN
    rv_pgm_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk      (sys_clk),
        .rst_n    (sys_rst),
        .i_load   (rx_valid),
        .i_enable (w_in_frame),
        .o_expire (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state     <= ST_RUN;
            r_hlt       <= 1'b0;
            r_pgm_mode  <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_core_rst  <= 1'b0;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
            r_idx       <= '0;
            r_len_lo    <= '0;
            r_len       <= '0;
            r_csum      <= '0;
            r_rst_cnt   <= '0;
        end else begin
            r_we        <= 1'b0;
            r_load_done <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (w_sync) begin
                        r_state    <= ST_LEN_LO;
                        r_hlt      <= 1'b1;
                        r_pgm_mode <= 1'b1;
                    end
                end
                ST_LEN_LO: begin
                    if (rx_valid) begin
                        r_len_lo <= rx_data;
                        r_state  <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (rx_valid) begin
                        r_len  <= w_len_rx;
                        r_idx  <= '0;
                        r_csum <= '0;
                        if (w_len_bad) begin
                            r_state    <= ST_ERR;
                            r_load_err <= 1'b1;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    // A SYNC byte here is payload; only the length ends the frame.
                    if (rx_valid) begin
                        r_we   <= 1'b1;
                        r_addr <= r_idx;
                        r_data <= rx_data;
                        r_csum <= r_csum + rx_data;
                        r_idx  <= r_idx + 10'd1;
                        if (w_last) r_state <= ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    if (rx_valid) begin
                        if (rx_data == r_csum) begin
                            r_state    <= ST_RELEASE;
                            r_core_rst <= 1'b1;
                            r_rst_cnt  <= '0;
                        end else begin
                            r_state    <= ST_ERR;
                            r_load_err <= 1'b1;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (r_rst_cnt == 16'(RST_CYC - 1)) begin
                        r_core_rst  <= 1'b0;
                        r_hlt       <= 1'b0;
                        r_pgm_mode  <= 1'b0;
                        r_load_done <= 1'b1;
                        r_state     <= ST_RUN;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 16'd1;
                    end
                end
                ST_ERR: begin
                    if (w_sync) begin
                        r_state    <= ST_LEN_LO;
                        r_load_err <= 1'b0;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
            // Gap expiry only matters when no byte arrived this cycle.
            if (w_in_frame && !rx_valid && w_timeout) begin
                r_state    <= ST_ERR;
                r_load_err <= 1'b1;
            end
        end
    end

    assign hlt         = r_hlt;
    assign pgm_mode    = r_pgm_mode;
    assign inst_mem_we = r_we;
    assign pgm_addr    = r_addr;
    assign pgm_data    = r_data;
    assign core_rst    = r_core_rst;
    assign load_done   = r_load_done;
    assign load_err    = r_load_err;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_rv_pgm_loader.sv
// Self-checking bench for rv_pgm_loader: directed frames plus randomized frames
// scored against a frame-level model of the load protocol.
module tb_rv_pgm_loader;

    localparam int IMEM_BYTES = 1024;
    localparam int RST_CYC    = 4;
`ifdef RV_PGM_LOADER_TIMEOUT_EN
    localparam int TIMEOUT_CYC = 50;
`else
    localparam int TIMEOUT_CYC = 100000;
`endif

    typedef logic [7:0] bq_t[$];

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       hlt, pgm_mode, inst_mem_we, core_rst, load_done, load_err;
    logic [9:0] pgm_addr;
    logic [7:0] pgm_data;
    logic [2:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int core_rst_cycles = 0;
    int load_done_cnt = 0;
    logic [17:0] exp_q[$];

    rv_pgm_loader #(
        .IMEM_BYTES  (IMEM_BYTES),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .RST_CYC     (RST_CYC)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .hlt         (hlt),
        .pgm_mode    (pgm_mode),
        .inst_mem_we (inst_mem_we),
        .pgm_addr    (pgm_addr),
        .pgm_data    (pgm_data),
        .core_rst    (core_rst),
        .load_done   (load_done),
        .load_err    (load_err),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // scoreboard: every write strobe must match the head of the expected queue
    always @(negedge sys_clk) begin
        if (sys_rst) begin
            if (inst_mem_we) begin
                if (exp_q.size() == 0)
                    check("unexpected_write", {14'd0, pgm_addr, pgm_data}, 32'hFFFF_FFFF);
                else
                    check("write", {14'd0, pgm_addr, pgm_data}, {14'd0, exp_q.pop_front()});
            end
            if (core_rst) core_rst_cycles++;
            if (load_done) load_done_cnt++;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hlt"},   {31'd0, hlt}, 32'd0);
        check({tag, "_pmode"}, {31'd0, pgm_mode}, 32'd0);
        check({tag, "_we"},    {31'd0, inst_mem_we}, 32'd0);
        check({tag, "_addr"},  {22'd0, pgm_addr}, 32'd0);
        check({tag, "_data"},  {24'd0, pgm_data}, 32'd0);
        check({tag, "_crst"},  {31'd0, core_rst}, 32'd0);
        check({tag, "_done"},  {31'd0, load_done}, 32'd0);
        check({tag, "_err"},   {31'd0, load_err}, 32'd0);
    endtask

    // driver
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        @(negedge sys_clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge sys_clk);
        rx_valid = 1'b0;
        repeat ($urandom_range(0, max_gap)) @(negedge sys_clk);
    endtask

    // reference model: decide outcome and writes from the frame bytes alone
    task automatic run_frame(input string tag, input bq_t f);
        int  len;
        bit  good_len, err;
        logic [7:0] sum;
        len      = int'(f[1]) + 256 * int'(f[2]);
        good_len = (len >= 1) && (len <= IMEM_BYTES);
        err      = 1'b1;
        sum      = 8'd0;
        if (good_len) begin
            for (int i = 0; i < len; i++) begin
                exp_q.push_back({10'(i), f[3 + i]});
                sum = sum + f[3 + i];
            end
            err = (f[3 + len] != sum);
        end
        core_rst_cycles = 0;
        load_done_cnt   = 0;
        for (int i = 0; i < f.size(); i++) begin
            send_byte(f[i], 2);
            if (i == 0) begin
                check({tag, "_hlt_after_sync"}, {31'd0, hlt}, 32'd1);
                check({tag, "_err_cleared"}, {31'd0, load_err}, 32'd0);
            end
        end
        repeat (RST_CYC + 4) @(negedge sys_clk);
        check({tag, "_writes_drained"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_core_rst_cycles"}, 32'(core_rst_cycles), err ? 32'd0 : 32'(RST_CYC));
        check({tag, "_load_done"}, 32'(load_done_cnt), err ? 32'd0 : 32'd1);
        check({tag, "_load_err"}, {31'd0, load_err}, {31'd0, err});
        check({tag, "_hlt"}, {31'd0, hlt}, {31'd0, err});
        check({tag, "_pgm_mode"}, {31'd0, pgm_mode}, {31'd0, err});
        exp_q.delete();
    endtask

    task automatic make_frame(output bq_t f, input int len, input bit bad_csum);
        logic [7:0] sum, b;
        f   = {8'hA5, 8'(len), 8'(len >> 8)};
        sum = 8'd0;
        if (len >= 1 && len <= IMEM_BYTES) begin
            for (int i = 0; i < len; i++) begin
                b = ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
                f.push_back(b);
                sum = sum + b;
            end
            f.push_back(bad_csum ? sum + 8'($urandom_range(1, 255)) : sum);
        end
    endtask

    initial begin
        bq_t f;
        int  len, n;
        // reset
        repeat (3) @(negedge sys_clk);
        check_reset_outputs("reset");
        sys_rst = 1'b1;
        @(negedge sys_clk);

        // noise in RUN is ignored
        for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 164)), 1);
        check("noise_hlt", {31'd0, hlt}, 32'd0);
        check("noise_err", {31'd0, load_err}, 32'd0);

        run_frame("good4", '{8'hA5, 8'h04, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13});
        run_frame("badcs", '{8'hA5, 8'h04, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h14});
        send_byte(8'h33, 1);
        check("err_ignore_hlt", {31'd0, hlt}, 32'd1);
        run_frame("err_rec", '{8'hA5, 8'h01, 8'h00, 8'h7F, 8'h7F});
        run_frame("len1025", '{8'hA5, 8'h01, 8'h04});
        run_frame("len0", '{8'hA5, 8'h00, 8'h00});

        for (int t = 0; t < 24; t++) begin
            n = $urandom_range(0, 9);
            if (n == 0) len = ($urandom_range(0, 1) == 0) ? 0 : 1025 + $urandom_range(0, 200);
            else        len = $urandom_range(1, 16);
            make_frame(f, len, n == 1);
            run_frame($sformatf("rnd%0d", t), f);
        end

`ifdef RV_PGM_LOADER_TIMEOUT_EN
        core_rst_cycles = 0;
        exp_q.push_back({10'd0, 8'h11});
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        n = 0;
        while (!load_err && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        check("timeout_cycles", 32'(n), 32'(TIMEOUT_CYC));
        check("timeout_hlt", {31'd0, hlt}, 32'd1);
        check("timeout_crst", 32'(core_rst_cycles), 32'd0);
        exp_q.delete();
`endif

        // asynchronous reset in the middle of DATA
        exp_q.push_back({10'd0, 8'h21});
        exp_q.push_back({10'd1, 8'h22});
        send_byte(8'hA5, 0);
        send_byte(8'h05, 0);
        send_byte(8'h00, 0);
        send_byte(8'h21, 0);
        send_byte(8'h22, 0);
        #2 sys_rst = 1'b0;
        #1 check_reset_outputs("midrst");
        check("midrst_writes_seen", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        make_frame(f, 6, 1'b0);
        run_frame("after_rst", f);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rv_pgm_loader.md
RV_PGM_LOADER -- requirements
Module: rv_pgm_loader

Interface
REQ-001 Parameter IMEM_BYTES, 1024, instruction-memory size in bytes; legal payload lengths are 1..IMEM_BYTES.
REQ-002 Parameter SYNC_BYTE, 8'hA5, frame start byte.
REQ-003 Parameter TIMEOUT_CYC, 100000, maximum sys_clk cycles allowed between frame bytes.
REQ-004 Parameter RST_CYC, 4, length of the core_rst pulse in cycles.
REQ-005 sys_clk  in  1  single clock; all logic on its rising edge.
REQ-006 sys_rst  in  1  reset, asynchronous assert, active-low.
REQ-007 rx_valid  in  1  one-cycle strobe: rx_data holds a received UART byte.
REQ-008 rx_data  in  8  received byte.
REQ-009 hlt  out  1  core halt; drives the core's hlt input.
REQ-010 pgm_mode  out  1  instruction-memory program-address select.
REQ-011 inst_mem_we  out  1  one-cycle instruction-memory byte write strobe.
REQ-012 pgm_addr  out  10  byte write address.
REQ-013 pgm_data  out  8  byte write data.
REQ-014 core_rst  out  1  active-high core reset pulse issued after a good load.
REQ-015 load_done  out  1  one-cycle pulse when the core is released after a good load.
REQ-016 load_err  out  1  sticky error flag; cleared by the next SYNC_BYTE or by reset.

Function
REQ-017 States: RUN, LEN_LO, LEN_HI, DATA, CSUM, RELEASE, ERR.
REQ-018 RUN: hlt=0, pgm_mode=0; rx_valid with rx_data==SYNC_BYTE -> LEN_LO, with hlt=1 and pgm_mode=1 from the next cycle; any other byte is ignored.
REQ-019 LEN_LO/LEN_HI capture the 16-bit little-endian length; a length of 0 or above IMEM_BYTES -> ERR.
REQ-020 DATA: each rx_valid produces inst_mem_we=1 for exactly one cycle, the following cycle, with pgm_addr=byte index (starting at 0) and pgm_data=byte; the index increments after each write.
REQ-021 After the byte at index length-1 is written -> CSUM.
REQ-022 Checksum is the 8-bit modulo-256 sum of the payload bytes; a received byte equal to the checksum -> RELEASE, otherwise -> ERR.
REQ-023 RELEASE: core_rst=1 for RST_CYC cycles with hlt held at 1; then hlt=0, pgm_mode=0, load_done pulses once, and the state returns to RUN.
REQ-024 ERR: hlt=1, pgm_mode=1, load_err=1; SYNC_BYTE -> LEN_LO with load_err cleared; other bytes are ignored.
REQ-025 A SYNC_BYTE received mid-frame is treated as data, not as a restart.
REQ-026 hlt is asserted no later than one cycle after the sync byte and stays high through RELEASE.
REQ-027 pgm_addr and pgm_data are registered and hold their last values when inst_mem_we=0.
REQ-028 inst_mem_we is never asserted outside DATA.
REQ-029 The instruction memory is clocked from sys_clk in the integrating top level.

Reset
REQ-030 While sys_rst=0: state RUN; hlt=0, pgm_mode=0, inst_mem_we=0, pgm_addr=0, pgm_data=0, core_rst=0, load_done=0, load_err=0; index, length, checksum and timer all cleared.
REQ-031 A reset mid-frame abandons the frame immediately; bytes already written stay in memory.

Configuration
REQ-032 With RV_PGM_LOADER_TIMEOUT_EN defined: in LEN_LO, LEN_HI, DATA and CSUM, a gap of TIMEOUT_CYC cycles with no rx_valid -> ERR; the timer reloads on each rx_valid.
REQ-033 Without the macro: no timer logic exists and the loader waits indefinitely between bytes.

Structure
REQ-034 State encodings, SYNC_BYTE and default parameter values live in the shared package rv_soc_pkg.
REQ-035 The inter-byte timer is sub-module rv_pgm_timeout (load, enable, expire outputs), instantiated only under the macro.

Verification
REQ-036 Frame A5 04 00 13 00 00 00 13 -> four writes at addresses 0..3 with data 13,00,00,00; core_rst high for 4 cycles; load_done pulses once; hlt returns to 0.
REQ-037 Same frame with checksum 14 -> load_err=1, hlt stays 1, core_rst never asserted.
REQ-038 Length 01 04 (1025) -> ERR immediately, with no inst_mem_we.
REQ-039 With the macro defined and TIMEOUT_CYC=50: A5 02 00 11 followed by silence -> load_err rises 50 cycles after the last rx_valid.
REQ-040 sys_rst driven low during DATA after 2 writes -> all outputs return to their reset values asynchronously; a new full frame then loads correctly.
REQ-041 In ERR, receiving A5 01 00 7F 7F -> load_err clears, one write of 7F at address 0, then load_done pulses.
